calendar_set_ctrl: RTL and testbench

//  Set-mode sequencer for the calendar counter. Turns debounced MODE/UP/DOWN keys into one-cycle
//  cnt_inc/cnt_dec field pulses (with auto-repeat), selects the field being edited, and gates the
//  day-carry full_flag while editing. Sits between the key debouncers and the calendar counter;

---
 rtl/calendar_set_ctrl_if.sv | 24 ++
 rtl/calendar_set_ctrl.sv | 163 ++++++++++++++++
 tb/tb_calendar_set_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/calendar_set_ctrl_if.sv
// Key inputs and counter/display outputs of the calendar set-mode sequencer.
// The slave side is the sequencer; the master side is its environment.
interface calendar_set_ctrl_if;
  logic       key_mode;
  logic       key_up;
  logic       key_down;
  logic       day_carry;
  logic [2:0] cnt_inc;
  logic [2:0] cnt_dec;
  logic       full_flag;
  logic       set_mode;
  logic [1:0] field_sel;
  logic [2:0] blink_mask;

  modport master (
    output key_mode, key_up, key_down, day_carry,
    input  cnt_inc, cnt_dec, full_flag, set_mode, field_sel, blink_mask
  );

  modport slave (
    input  key_mode, key_up, key_down, day_carry,
    output cnt_inc, cnt_dec, full_flag, set_mode, field_sel, blink_mask
  );
endinterface

// File: rtl/calendar_set_ctrl.sv
// Set-mode sequencer for the calendar counter: key edges and auto-repeat to
// per-field inc/dec pulses, set-mode timeout, day-carry gating and field blink.
module calendar_set_ctrl #(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000,
  parameter int TIMEOUT    = 500_000_000,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic               Clk,
  input  logic               Reset,
  calendar_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, SET_YEAR, SET_MONTH, SET_DAY} state_t;

  localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int HOLD_W   = $clog2(HOLD_MAX);
  localparam int TMO_W    = $clog2(TIMEOUT);
  localparam int BLK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  function automatic logic [1:0] field_code(input state_t s);
    case (s)
      SET_DAY:   field_code = 2'd1;
      SET_MONTH: field_code = 2'd2;
      SET_YEAR:  field_code = 2'd3;
      default:   field_code = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] field_onehot(input state_t s);
    case (s)
      SET_DAY:   field_onehot = 3'b001;
      SET_MONTH: field_onehot = 3'b010;
      SET_YEAR:  field_onehot = 3'b100;
      default:   field_onehot = 3'b000;
    endcase
  endfunction

  state_t            state, state_nxt;
  logic              mode_q, up_q, down_q;
  logic [HOLD_W-1:0] hold_cnt, rpt_target;
  logic              hold_act, hold_up, hold_rpt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [BLK_W-1:0]  blink_cnt;
  logic              blink_ph, blink_ph_nxt, blink_wrap;
  logic              carry_pend;

  logic mode_edge, up_edge, down_edge, any_key, one_key, in_set, tmo_hit;
  logic stay, new_press, hold_keep, rpt_fire, pulse_up;

  // NOTE: every signal gets a default at the top so no path infers a latch.
  always_comb begin
    mode_edge = bus.key_mode & ~mode_q;
    up_edge   = bus.key_up   & ~up_q;
    down_edge = bus.key_down & ~down_q;
    any_key   = bus.key_mode | bus.key_up | bus.key_down;
    one_key   = bus.key_up ^ bus.key_down;
    in_set    = (state != RUN);
    tmo_hit   = in_set && !any_key && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    state_nxt = state;
    if (mode_edge) begin
      case (state)
        RUN:       state_nxt = SET_YEAR;
        SET_YEAR:  state_nxt = SET_MONTH;
        SET_MONTH: state_nxt = SET_DAY;
        default:   state_nxt = RUN;
      endcase
    end else if (tmo_hit) begin
      state_nxt = RUN;
    end

    // Inc/dec only while the field stays put, so a mode change always wins.
    stay       = in_set && (state_nxt == state);
    new_press  = stay && one_key && (up_edge || down_edge);
    hold_keep  = stay && hold_act && one_key && (bus.key_up == hold_up) && !new_press;
    rpt_target = hold_rpt ? HOLD_W'(REPEAT_PER - 1) : HOLD_W'(REPEAT_DLY - 1);
    rpt_fire   = hold_keep && (hold_cnt == rpt_target);
    pulse_up   = new_press ? bus.key_up : hold_up;

    blink_wrap   = (blink_cnt == BLK_W'(BLINK_HALF - 1));
    blink_ph_nxt = stay ? (blink_ph ^ blink_wrap) : 1'b0;
  end

  // NOTE: non-blocking throughout, so every register sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= RUN;
      mode_q         <= 1'b0;
      up_q           <= 1'b0;
      down_q         <= 1'b0;
      hold_cnt       <= '0;
      hold_act       <= 1'b0;
      hold_up        <= 1'b0;
      hold_rpt       <= 1'b0;
      tmo_cnt        <= '0;
      blink_cnt      <= '0;
      blink_ph       <= 1'b0;
      carry_pend     <= 1'b0;
      bus.cnt_inc    <= 3'b000;
      bus.cnt_dec    <= 3'b000;
      bus.full_flag  <= 1'b0;
      bus.set_mode   <= 1'b0;
      bus.field_sel  <= 2'd0;
      bus.blink_mask <= 3'b000;
    end else begin
      state  <= state_nxt;
      mode_q <= bus.key_mode;
      up_q   <= bus.key_up;
      down_q <= bus.key_down;

      bus.set_mode  <= (state_nxt != RUN);
      bus.field_sel <= field_code(state_nxt);

      if (any_key || state_nxt == RUN) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + TMO_W'(1);

      // Repeat interval switches from REPEAT_DLY to REPEAT_PER after the first repeat.
      if (new_press) begin
        hold_act <= 1'b1;
        hold_up  <= bus.key_up;
        hold_rpt <= 1'b0;
        hold_cnt <= '0;
      end else if (hold_keep) begin
        if (rpt_fire) begin
          hold_rpt <= 1'b1;
          hold_cnt <= '0;
        end else begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end else begin
        hold_act <= 1'b0;
        hold_rpt <= 1'b0;
        hold_cnt <= '0;
      end

      bus.cnt_inc <= 3'b000;
      bus.cnt_dec <= 3'b000;
      if (new_press || rpt_fire) begin
        if (pulse_up) bus.cnt_inc <= field_onehot(state);
        else          bus.cnt_dec <= field_onehot(state);
      end

      // Carries are released only when the next state is RUN, which is exactly
      // when no inc/dec pulse can be issued; a carry landing on a pending one
      // is held over one cycle.
      if (state_nxt == RUN) begin
        bus.full_flag <= bus.day_carry | carry_pend;
        carry_pend    <= bus.day_carry & carry_pend;
      end else begin
        bus.full_flag <= 1'b0;
        carry_pend    <= carry_pend | bus.day_carry;
      end

      if (!stay || blink_wrap) blink_cnt <= '0;
      else                     blink_cnt <= blink_cnt + BLK_W'(1);
      blink_ph       <= blink_ph_nxt;
      bus.blink_mask <= (blink_ph_nxt && !(bus.key_up || bus.key_down))
                        ? field_onehot(state_nxt) : 3'b000;
    end
  end

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Randomized and directed bench for calendar_set_ctrl against a cycle-level
// behavioural model built from key ages and per-state elapsed-cycle counts.
module tb_calendar_set_ctrl;

  localparam int REPEAT_DLY = 8;
  localparam int REPEAT_PER = 4;
  localparam int TIMEOUT    = 40;
  localparam int BLINK_HALF = 3;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  calendar_set_ctrl_if bus();

  calendar_set_ctrl #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER),
    .TIMEOUT   (TIMEOUT),
    .BLINK_HALF(BLINK_HALF)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 RUN, 1 YEAR, 2 MONTH, 3 DAY (mode key steps +1 mod 4).
  int m_st;
  int m_idle;
  int m_age;
  int m_bage;
  bit m_active, m_dir, m_pend;
  bit m_pm, m_pu, m_pd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] onehot_of(input int s);
    logic [2:0] one;
    one = 3'b001;
    onehot_of = (s == 0) ? 3'b000 : (one << (3 - s));
  endfunction

  task automatic tick();
    logic       m, u, d, dc, rst, mode_e, stay, fire;
    logic [2:0] e_inc, e_dec, e_blk;
    logic       e_full;
    int         nxt;
    @(posedge Clk);
    m = bus.key_mode; u = bus.key_up; d = bus.key_down;
    dc = bus.day_carry; rst = Reset;
    e_inc = 3'b000; e_dec = 3'b000; e_blk = 3'b000; e_full = 1'b0;
    if (rst) begin
      m_st = 0; m_idle = 0; m_age = 0; m_bage = 0;
      m_active = 0; m_dir = 0; m_pend = 0;
      m_pm = 0; m_pu = 0; m_pd = 0;
    end else begin
      mode_e = m && !m_pm;
      if (m_st == 0 || m || u || d) m_idle = 0;
      else m_idle++;
      nxt = m_st;
      if (mode_e) nxt = (m_st + 1) % 4;
      else if (m_idle == TIMEOUT) nxt = 0;
      if (nxt != m_st || nxt == 0) m_idle = 0;
      stay = (m_st != 0) && (nxt == m_st);

      fire = 1'b0;
      if (stay && (u ^ d) && ((u && !m_pu) || (d && !m_pd))) begin
        m_active = 1; m_dir = u; m_age = 0; fire = 1'b1;
      end else if (stay && m_active && (u ^ d) && (u == m_dir)) begin
        m_age++;
        fire = (m_age >= REPEAT_DLY) && ((m_age - REPEAT_DLY) % REPEAT_PER == 0);
      end else begin
        m_active = 0;
      end
      if (fire) begin
        if (m_dir) e_inc = onehot_of(m_st);
        else       e_dec = onehot_of(m_st);
      end

      if (nxt == 0) begin
        e_full = dc || m_pend;
        m_pend = dc && m_pend;
      end else begin
        m_pend = m_pend || dc;
      end

      if (stay) m_bage++;
      else      m_bage = 0;
      if (nxt != 0 && ((m_bage / BLINK_HALF) % 2 == 1) && !(u || d)) e_blk = onehot_of(nxt);

      m_st = nxt; m_pm = m; m_pu = u; m_pd = d;
    end
    #1;
    check("cnt_inc",    32'(bus.cnt_inc),    32'(e_inc));
    check("cnt_dec",    32'(bus.cnt_dec),    32'(e_dec));
    check("full_flag",  32'(bus.full_flag),  32'(e_full));
    check("set_mode",   32'(bus.set_mode),   32'(m_st != 0));
    check("field_sel",  32'(bus.field_sel),  (m_st == 0) ? 32'd0 : 32'(4 - m_st));
    check("blink_mask", 32'(bus.blink_mask), 32'(e_blk));
    check("exclusive",  32'($countones({bus.cnt_inc, bus.cnt_dec, bus.full_flag}) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic keys(input logic m, input logic u, input logic d);
    bus.key_mode = m; bus.key_up = u; bus.key_down = d;
  endtask

  task automatic tap();
    bus.key_mode = 1'b1; run(2);
    bus.key_mode = 1'b0; run(2);
  endtask

  task automatic carry_pulse();
    bus.day_carry = 1'b1; tick();
    bus.day_carry = 1'b0; run(2);
  endtask

  initial begin
    Reset = 1'b1;
    keys(0, 0, 0);
    bus.day_carry = 1'b0;
    run(3);
    Reset = 1'b0;
    run(2);

    // Mode walk through all fields and back to RUN.
    tap(); tap(); tap(); tap();
    run(2);

    // Held UP in SET_MONTH with auto-repeat.
    tap(); tap();
    keys(0, 1, 0); run(20);
    keys(0, 0, 0); run(2);
    keys(0, 0, 1); run(14);
    keys(0, 0, 0); run(2);

    // SET_DAY: UP+DOWN together, release DOWN, then a fresh UP press.
    tap();
    keys(0, 1, 1); run(4);
    keys(0, 1, 0); run(12);
    keys(0, 0, 0); run(1);
    keys(0, 1, 0); run(3);
    keys(0, 0, 0); run(1);
    tap();
    run(2);

    // Carry passthrough in RUN, then two carries gated in SET_YEAR.
    carry_pulse();
    tap();
    carry_pulse();
    carry_pulse();
    tap(); tap(); tap();
    run(3);

    // Idle timeout from SET_YEAR with blink windows along the way.
    tap();
    run(TIMEOUT + 6);

    // Reset held mid-repeat.
    tap(); tap();
    keys(0, 1, 0); run(12);
    Reset = 1'b1; run(3);
    Reset = 1'b0; keys(0, 0, 0); run(2);

    // Randomized traffic with occasional idle bursts and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  bus.key_up   = ~bus.key_up;
      if ($urandom_range(0, 7) == 0)  bus.key_down = ~bus.key_down;
      if ($urandom_range(0, 11) == 0) bus.key_mode = ~bus.key_mode;
      bus.day_carry = ($urandom_range(0, 9) == 0);
      Reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) begin
        keys(0, 0, 0);
        bus.day_carry = 1'b0;
        Reset = 1'b0;
        run(TIMEOUT + 5);
      end
      tick();
    end

    Reset = 1'b0;
    keys(0, 0, 0);
    bus.day_carry = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
